// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers (polynomial 0x11B) for the inverse cipher round path.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_state_e;

  localparam int NR = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multipliers built from a single xtime chain: x2, x4, x8.
  function automatic logic [7:0] gmul09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gmul0b(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gmul0d(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gmul0e(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Same XOR used by the encryption round path; AddRoundKey is self-inverse.
  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  // Byte i = row + 4*col sits at [127-8i -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
      o[127-8*(4*c+1) -: 8] = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
      o[127-8*(4*c+2) -: 8] = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
      o[127-8*(4*c+3) -: 8] = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, table lookup.
module aes_inv_sbox (
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  // Entry 0 occupies the top byte of the table.
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  logic [10:0] base;
  assign base   = {byte_i, 3'b000};
  assign byte_o = INV_SBOX_TBL[11'd2047 - base -: 8];

endmodule

// File: rtl/aes128_decr_core.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched by index.
// Optional AES_DECR_ABORT_EN adds an abort input that returns ROUND/DONE to IDLE.
module aes128_decr_core #(
  parameter int NR = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef AES_DECR_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_RK = 4'(NR);

  aes_state_e   state_q;
  logic [3:0]   round_q;
  logic [127:0] blk_q;
  logic [127:0] pt_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;

  logic [127:0] shifted;
  logic [127:0] sub_bytes;
  logic [127:0] keyed;
  logic [127:0] mixed;
  logic         abort_hit;

  assign shifted = inv_shift_rows(blk_q);

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
      aes_inv_sbox u_sbox (
        .byte_i (shifted[127-8*gi -: 8]),
        .byte_o (sub_bytes[127-8*gi -: 8])
      );
    end
  endgenerate

  // Final round uses keyed directly; middle rounds add InvMixColumns.
  assign keyed = add_round_key(sub_bytes, rk);
  assign mixed = inv_mix_columns(keyed);

  assign rk_idx = (state_q == ROUND) ? round_q : LAST_RK;

`ifdef AES_DECR_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_q     <= LAST_RK;
      blk_q       <= '0;
      pt_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort_hit) begin
      state_q     <= IDLE;
      round_q     <= LAST_RK;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            blk_q      <= add_round_key(ciphertext, rk);
            round_q    <= LAST_RK - 4'd1;
            state_q    <= ROUND;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ROUND: begin
          if (round_q == 4'd0) begin
            pt_q        <= keyed;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            blk_q   <= mixed;
            round_q <= round_q - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            round_q     <= LAST_RK;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes128_decr_core.sv
// Scoreboard bench for aes128_decr_core; key store expanded here from the cipher key.
module tb_aes128_decr_core;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] rk;
  logic         in_ready, out_valid, busy;
  logic [3:0]   rk_idx;
  logic [127:0] plaintext;
`ifdef AES_DECR_ABORT_EN
  logic         abort = 1'b0;
`endif

  aes128_decr_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_DECR_ABORT_EN
    .abort      (abort),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .rk_idx     (rk_idx),
    .rk         (rk),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [127:0] rk_mem [0:10];
  assign rk = (rk_idx <= 4'd10) ? rk_mem[rk_idx] : '0;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [127:0] exp_pt = '0;
  int           acc_count = 0;
  int           done_count = 0;
  int           acc_last = 0;
  int           acc_prev = 0;
  logic         prev_ov = 1'b0;
  logic         logging = 1'b0;
  logic [43:0]  rk_log = '0;
  int           nlog = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %-20s got=%h want=%h", tag, got, want);
    end else begin
      $display("ok   %-20s %h", tag, got);
    end
  endtask

  // Reference GF(2^8) arithmetic and forward S-box (inverse + affine) for key expansion.
  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] tb_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a != 8'h00) begin
      v = 8'h01;
      for (int i = 0; i < 254; i++) v = tb_gmul(v, a);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0]), tb_sbox(t[31:24])} ^ {rc, 24'h0};
        rc = tb_xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Monitor: push on accept, check key-index order and latency on out_valid rise, pop on handshake.
  always @(negedge clk) begin
    int lat;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
      logging = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(exp_pt);
        acc_q.push_back(cyc);
        acc_prev = acc_last;
        acc_last = cyc;
        acc_count++;
        rk_log  = {40'h0, rk_idx};
        nlog    = 1;
        logging = 1'b1;
      end else if (logging && busy && !out_valid) begin
        rk_log = {rk_log[39:0], rk_idx};
        nlog++;
      end
      if (out_valid && !prev_ov) begin
        logging = 1'b0;
        check_val("rk_seq", {76'h0, 8'(nlog), rk_log}, {76'h0, 8'd11, 44'hA9876543210});
        lat = (acc_q.size() == 0) ? -1 : cyc - acc_q.pop_front();
        check_val("latency", 128'(lat), 128'd11);
      end
      if (out_valid && out_ready) begin
        done_count++;
        check_val("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
        if (exp_q.size() != 0) check_val("plaintext", plaintext, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int start;
    start      = acc_count;
    ciphertext = ct;
    exp_pt     = pt;
    in_valid   = 1'b1;
    for (int n = 0; n < 100 && acc_count == start; n++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_val("accepted", 128'(acc_count - start), 128'd1);
  endtask

  task automatic wait_done(input int target);
    for (int n = 0; n < 200 && done_count < target; n++) begin
      @(posedge clk); #1;
    end
    check_val("handshakes", 128'(done_count), 128'(target));
  endtask

  task automatic wait_rk(input logic [3:0] idx);
    for (int n = 0; n < 20 && rk_idx != idx; n++) begin
      @(posedge clk); #1;
    end
    check_val("rk_reached", 128'(rk_idx), 128'(idx));
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_in_ready"}, 128'(in_ready), 128'd1);
    check_val({pfx, "_out_valid"}, 128'(out_valid), 128'd0);
    check_val({pfx, "_busy"}, 128'(busy), 128'd0);
    check_val({pfx, "_rk_idx"}, 128'(rk_idx), 128'd10);
  endtask

  task automatic expect_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check_val(tag, 128'(seen), 128'd0);
  endtask

  initial begin
    logic [127:0] held;
    logic         stable;

    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check_val("rst_plaintext", plaintext, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_key(KEY_C1);
    out_ready = 1'b1;
    send(CT_C1, PT_C1);
    wait_done(1);

    load_key(KEY_B);
    send(CT_B, PT_B);
    wait_done(2);

    // Backpressure: DONE must hold for 20 cycles, then one ready cycle releases it.
    load_key(KEY_C1);
    out_ready = 1'b0;
    send(CT_C1, PT_C1);
    for (int n = 0; n < 50 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    check_val("bp_valid", 128'(out_valid), 128'd1);
    held   = plaintext;
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || plaintext !== held) stable = 1'b0;
    end
    check_val("bp_stable", 128'(stable), 128'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_rel_in_ready", 128'(in_ready), 128'd1);
    check_val("bp_rel_out_valid", 128'(out_valid), 128'd0);
    wait_done(3);

    // Back-to-back with in_valid held: second accept only after first handshake.
    send(CT_C1, PT_C1);
    send(CT_C1, PT_C1);
    check_val("b2b_spacing", 128'(acc_last - acc_prev), 128'd12);
    wait_done(5);

    // Asynchronous reset in round 5 discards the block.
    send(CT_C1, PT_C1);
    wait_rk(4'd5);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check_val("rst_mid_plaintext", plaintext, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_no_valid("rst_no_valid", 15);
    send(CT_C1, PT_C1);
    wait_done(6);

`ifdef AES_DECR_ABORT_EN
    send(CT_C1, PT_C1);
    wait_rk(4'd3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_idle_outputs("abort");
    exp_q.delete();
    acc_q.delete();
    expect_no_valid("abort_no_valid", 15);
    send(CT_C1, PT_C1);
    wait_done(7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes128_decr_core.md
Name: aes128_decr_core

Overview:
Iterative AES-128 inverse cipher, FIPS-197 "InvCipher" order. It is the decryption counterpart of the encryption round path. It processes one round per clock and reads round keys from the shared precomputed key store through an index/data port. It sits between the host byte-loader (ciphertext in) and the output shifter (plaintext out).

Parameters:
NR, 10, number of AES rounds (fixed to 10 for AES-128; parameterised only for clarity and checks)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext valid
in_ready  output  1  core can accept ciphertext (high only in IDLE)
ciphertext  input  128  block to decrypt, byte 0 in [127:120]
rk_idx  output  4  round-key index requested (0..10)
rk  input  128  round key for rk_idx, combinational same-cycle from key store
out_valid  output  1  plaintext valid
out_ready  input  1  downstream accepts plaintext
plaintext  output  128  decrypted block, byte 0 in [127:120]
busy  output  1  high in ROUND or DONE

Behaviour:
- Reset, async assert / sync deassert of effect:
  - state=IDLE, round counter=4'd10, state register=0, plaintext=0.
  - in_ready=1, out_valid=0, busy=0, rk_idx=4'd10 (rk_idx is driven as 10 in IDLE).
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - On in_valid&&in_ready: state_reg <= ciphertext ^ rk (idx 10); round <= 9; go to ROUND.
- ROUND (rk_idx = round):
  - round 9..1: state_reg <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), rk)); round decrements.
  - round 0: plaintext <= InvSubBytes(InvShiftRows(state_reg)) ^ rk; go to DONE.
- DONE:
  - out_valid=1; plaintext is held stable until out_valid&&out_ready.
  - On handshake: go to IDLE with out_valid=0.
  - in_ready is 0 in DONE; there is no overlap of the next block.
- Latency: accept at cycle T gives out_valid at cycle T+11 (1 load + 10 round cycles). Throughput is one block per ≥12 cycles.
- Key-index sequence per block: 10,9,8,…,0, exactly once each.
- in_valid while not in IDLE is ignored; ciphertext is not captured.
- out_ready held high in advance: DONE lasts exactly one cycle.
- Reset asserted mid-round: output returns immediately to reset values. The partial state is discarded and no out_valid pulse occurs.
- All arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns uses coefficients 0e,0b,0d,09 built from xtime chains; there are no multipliers.

Optional Feature:
AES_DECR_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 in ROUND or DONE returns the core to IDLE next cycle. out_valid is forced 0 and plaintext is unchanged. abort has priority over the out handshake. abort in IDLE has no effect.
- Undefined: no abort port; behaviour exactly as above.

Decomposition:
- Shared package aes_pkg holds:
  - fsm state enum {IDLE, ROUND, DONE}
  - localparam NR=10
  - GF helper functions: xtime, gmul by 09/0b/0d/0e
  - inv_shift_rows and inv_mix_columns functions
- Sub-module aes_inv_sbox: combinational 8-bit lookup. The core instantiates 16 copies.
- The existing encryption AddRoundKey is reused as an XOR function/instance. It is not duplicated.

Test Plan:
- FIPS-197 C.1: key store loaded from key 000102030405060708090a0b0c0d0e0f; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after accept.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c; ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734. rk_idx observed as 10,9,…,0.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> plaintext and out_valid stable, in_ready=0. Then out_ready=1 for one cycle -> IDLE, in_ready=1.
- Back-to-back: two C.1 blocks with in_valid held high -> second is accepted only after first handshake; both plaintexts correct.
- Reset: rst_n pulsed low at round 5 -> all outputs at reset values the same cycle, no out_valid. A new C.1 block afterwards decrypts correctly.
- With AES_DECR_ABORT_EN: abort at round 3 -> IDLE next cycle, no out_valid. The next block decrypts to 00112233445566778899aabbccddeeff.
